// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with per-byte writes and a fixed response latency.
// Latency: dmem_resp_o fires LATENCY cycles after the acceptance edge (LATENCY = 1..15).
// Backpressure: dmem_busy_o high while a request is in flight; requests presented then are ignored.
// Optional: define DMEM_RESPONDER_ALIGN_CHECK_EN to add dmem_err_o and drop misaligned accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h6000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dmem_addr_i,
    input  logic [3:0]  dmem_rmask_i,
    input  logic [3:0]  dmem_wmask_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_resp_o,
    output logic        dmem_busy_o
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic        dmem_err_o
`endif
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    // Byte span of the array; 33 bits so the compare never overflows.
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [31:0]             hold_q;
    logic [31:0]             rdata_q;
    logic                    resp_q;

    logic [31:0]             mem_q [DEPTH];

    logic [31:0]             off;
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [3:0]              any_mask;
    logic                    accept;
    logic                    mis;
    logic                    ok;
    logic [31:0]             merged;
    logic [31:0]             lane_sel;
    logic [31:0]             rd_word;

    // Unsigned offset from the base: addresses below the base wrap to huge values and fail the range test.
    assign off      = dmem_addr_i - BASE_ADDR;
    assign in_range = ({1'b0, off} < SPAN);
    assign idx      = off[DEPTH_LOG2+1:2];
    assign any_mask = dmem_rmask_i | dmem_wmask_i;
    assign accept   = (state_q == ST_IDLE) && (any_mask != 4'b0000);

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    logic err_q;
    logic err_hold_q;
    logic [3:0] below_mask;

    // Misalignment: lanes enabled below the byte offset, or half/word masks off their natural boundary.
    always_comb begin
        below_mask = any_mask & ((4'b0001 << dmem_addr_i[1:0]) - 4'b0001);
        mis        = (below_mask != 4'b0000)
                   || (($countones(any_mask) == 2) && dmem_addr_i[0])
                   || (($countones(any_mask) == 4) && (dmem_addr_i[1:0] != 2'b00));
    end

    assign dmem_err_o = err_q;
`else
    assign mis = 1'b0;
`endif

    assign ok = in_range && !mis;

    // Read word as seen after this edge's write: written lanes take store data, then mask by rmask.
    always_comb begin
        merged   = mem_q[idx];
        lane_sel = '0;
        for (int n = 0; n < 4; n++) begin
            if (dmem_wmask_i[n]) begin
                merged[8*n +: 8] = dmem_wdata_i[8*n +: 8];
            end
            lane_sel[8*n +: 8] = {8{dmem_rmask_i[n]}};
        end
        rd_word = ok ? (merged & lane_sel) : 32'h0;
    end

    // Array write: committed only at the acceptance edge, per enabled byte lane, never under reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept && ok) begin
            for (int n = 0; n < 4; n++) begin
                if (dmem_wmask_i[n]) begin
                    mem_q[idx][8*n +: 8] <= dmem_wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Request FSM: accept in IDLE, count down in WAIT, raise a one-cycle response with held data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            hold_q     <= 32'h0;
            rdata_q    <= 32'h0;
            resp_q     <= 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
            err_q      <= 1'b0;
            err_hold_q <= 1'b0;
`endif
        end else begin
            resp_q <= 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q <= CNT_LOAD;
                        if (LATENCY > 1) begin
                            state_q    <= ST_WAIT;
                            hold_q     <= rd_word;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
                            err_hold_q <= mis;
`endif
                        end else begin
                            resp_q  <= 1'b1;
                            rdata_q <= rd_word;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
                            err_q   <= mis;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    // The edge that takes the counter from 1 to 0 is the one that raises the response.
                    if (cnt_q <= 4'd1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 4'd0;
                        resp_q  <= 1'b1;
                        rdata_q <= hold_q;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
                        err_q   <= err_hold_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_rdata_o = rdata_q;
    assign dmem_resp_o  = resp_q;
    assign dmem_busy_o  = (state_q == ST_WAIT);

endmodule
